// File: rtl/dht_frame_decoder.sv
// dht_frame_decoder: validates DHT sensor frames and converts the integer bytes to BCD
// Ports: clk1M/rst clock and sync reset; frame_in/mstate_in/flag_five_sec from the reader;
// hum_bcd/temp_bcd/hum_raw/temp_raw latched results with data_valid strobe;
// crc_err pulse, err_cnt saturating failure count, stale poll-miss flag, busy.
module dht_frame_decoder #(
    parameter int STALE_LIMIT = 3
) (
    input  logic        clk1M,
    input  logic        rst,
    input  logic [39:0] frame_in,
    input  logic [2:0]  mstate_in,
    input  logic        flag_five_sec,
    output logic [11:0] hum_bcd,
    output logic [11:0] temp_bcd,
    output logic [7:0]  hum_raw,
    output logic [7:0]  temp_raw,
    output logic        data_valid,
    output logic        crc_err,
    output logic [7:0]  err_cnt,
    output logic        stale,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CHECK, CONV, DONE} state_t;
    localparam logic [7:0] LIM = 8'(STALE_LIMIT);

    state_t      st_q, st_d;
    logic [2:0]  mst_q;
    logic [1:0]  ff_q;
    logic [39:0] frame_q, frame_d;
    logic [7:0]  hb_q, hb_d, tb_q, tb_d;
    logic [11:0] hd_q, hd_d, td_q, td_d, ha, ta;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] hbcd_q, hbcd_d, tbcd_q, tbcd_d;
    logic [7:0]  hraw_q, hraw_d, traw_q, traw_d, err_q, err_d, miss_q, miss_d, sum;
    logic        dv_q, dv_d, crc_q, crc_d, stale_q, stale_d, busy_q, busy_d;
    logic        eof, rise, ok;

    function automatic logic [11:0] adj(input logic [11:0] d);
        return {d[11:8] + (d[11:8] > 4'd4 ? 4'd3 : 4'd0),
                d[7:4]  + (d[7:4]  > 4'd4 ? 4'd3 : 4'd0),
                d[3:0]  + (d[3:0]  > 4'd4 ? 4'd3 : 4'd0)};
    endfunction

    always_comb begin
        eof     = mst_q == 3'd2 && mstate_in == 3'd0;
        rise    = ff_q == 2'b01;
        sum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
        ok      = sum == frame_q[7:0];
        ha      = adj(hd_q);
        ta      = adj(td_q);
        st_d    = st_q;
        frame_d = frame_q;
        hb_d    = hb_q;
        tb_d    = tb_q;
        hd_d    = hd_q;
        td_d    = td_q;
        cnt_d   = cnt_q;
        hbcd_d  = hbcd_q;
        tbcd_d  = tbcd_q;
        hraw_d  = hraw_q;
        traw_d  = traw_q;
        err_d   = err_q;
        dv_d    = 1'b0;
        crc_d   = 1'b0;
        case (st_q)
            IDLE: begin
                if (eof) begin
                    frame_d = frame_in;
                    st_d    = CHECK;
                end
            end
            CHECK: begin
                if (ok) begin
                    hb_d  = frame_q[39:32];
                    tb_d  = frame_q[23:16];
                    hd_d  = '0;
                    td_d  = '0;
                    cnt_d = '0;
                    st_d  = CONV;
                end else begin
                    crc_d = 1'b1;
                    err_d = err_q + {7'd0, err_q != 8'hff};
                    st_d  = IDLE;
                end
            end
            CONV: begin
                // shift-add-3: adjusted digits shift left with the binary MSB entering
                hd_d  = {ha[10:0], hb_q[7]};
                td_d  = {ta[10:0], tb_q[7]};
                hb_d  = {hb_q[6:0], 1'b0};
                tb_d  = {tb_q[6:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                st_d  = cnt_q == 3'd7 ? DONE : CONV;
            end
            default: begin
                hbcd_d = hd_q;
                tbcd_d = td_q;
                hraw_d = frame_q[39:32];
                traw_d = frame_q[23:16];
                dv_d   = 1'b1;
                st_d   = IDLE;
            end
        endcase
        // DONE outranks a coincident poll edge
        miss_d  = st_q == DONE ? 8'd0 : (rise && miss_q != LIM) ? miss_q + 8'd1 : miss_q;
        stale_d = miss_d == LIM;
        // registered busy spans the cycle after capture through the cycle after the final state
        busy_d  = st_d != IDLE || st_q != IDLE;
    end

    always_ff @(posedge clk1M) begin
        if (rst) begin
            st_q    <= IDLE;
            mst_q   <= '0;
            ff_q    <= '0;
            frame_q <= '0;
            hb_q    <= '0;
            tb_q    <= '0;
            hd_q    <= '0;
            td_q    <= '0;
            cnt_q   <= '0;
            hbcd_q  <= '0;
            tbcd_q  <= '0;
            hraw_q  <= '0;
            traw_q  <= '0;
            err_q   <= '0;
            miss_q  <= '0;
            dv_q    <= 1'b0;
            crc_q   <= 1'b0;
            stale_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            mst_q   <= mstate_in;
            ff_q    <= {ff_q[0], flag_five_sec};
            frame_q <= frame_d;
            hb_q    <= hb_d;
            tb_q    <= tb_d;
            hd_q    <= hd_d;
            td_q    <= td_d;
            cnt_q   <= cnt_d;
            hbcd_q  <= hbcd_d;
            tbcd_q  <= tbcd_d;
            hraw_q  <= hraw_d;
            traw_q  <= traw_d;
            err_q   <= err_d;
            miss_q  <= miss_d;
            dv_q    <= dv_d;
            crc_q   <= crc_d;
            stale_q <= stale_d;
            busy_q  <= busy_d;
        end
    end

    assign hum_bcd    = hbcd_q;
    assign temp_bcd   = tbcd_q;
    assign hum_raw    = hraw_q;
    assign temp_raw   = traw_q;
    assign data_valid = dv_q;
    assign crc_err    = crc_q;
    assign err_cnt    = err_q;
    assign stale      = stale_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_dht_frame_decoder.sv
// tb_dht_frame_decoder: directed and random frames checked against an arithmetic reference model
module tb_dht_frame_decoder;
    logic        clk1M = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] frame_in = '0;
    logic [2:0]  mstate_in = '0;
    logic        flag_five_sec = 1'b0;
    logic [11:0] hum_bcd, temp_bcd;
    logic [7:0]  hum_raw, temp_raw, err_cnt;
    logic        data_valid, crc_err, stale, busy;

    int passes = 0;
    int total = 0;

    logic [11:0] e_hbcd = '0, e_tbcd = '0;
    logic [7:0]  e_hraw = '0, e_traw = '0;
    int          e_err = 0;
    logic        e_stale = 1'b0;

    dht_frame_decoder #(.STALE_LIMIT(3)) dut (
        .clk1M(clk1M), .rst(rst), .frame_in(frame_in), .mstate_in(mstate_in),
        .flag_five_sec(flag_five_sec), .hum_bcd(hum_bcd), .temp_bcd(temp_bcd),
        .hum_raw(hum_raw), .temp_raw(temp_raw), .data_valid(data_valid),
        .crc_err(crc_err), .err_cnt(err_cnt), .stale(stale), .busy(busy)
    );

    always #5 clk1M = ~clk1M;

    task automatic tick();
        @(posedge clk1M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic good_sum(input logic [39:0] f);
        return ((int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256) == int'(f[7:0]);
    endfunction

    function automatic logic [39:0] make_frame(input logic good);
        logic [31:0] d;
        int s;
        d = $urandom;
        s = (int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0])) % 256;
        if (!good) s = (s + int'($urandom_range(1, 255))) % 256;
        return {d, 8'(s)};
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, " hum_bcd"}, 40'(hum_bcd), 40'(e_hbcd));
        chk({tag, " temp_bcd"}, 40'(temp_bcd), 40'(e_tbcd));
        chk({tag, " hum_raw"}, 40'(hum_raw), 40'(e_hraw));
        chk({tag, " temp_raw"}, 40'(temp_raw), 40'(e_traw));
    endtask

    // present one frame and end it; returns in the cycle after the capture edge
    task automatic start_frame(input logic [39:0] f);
        frame_in = f;
        mstate_in = 3'd2;
        tick();
        mstate_in = 3'd0;
        tick();
    endtask

    task automatic run_frame(input logic [39:0] f, input string tag);
        int lat;
        logic seen;
        start_frame(f);
        chk({tag, " busy"}, 40'(busy), 40'd1);
        if (good_sum(f)) begin
            e_hbcd = bcd(int'(f[39:32]));
            e_tbcd = bcd(int'(f[23:16]));
            e_hraw = f[39:32];
            e_traw = f[23:16];
            e_stale = 1'b0;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!data_valid && lat < 20);
            chk({tag, " latency"}, 40'(lat), 40'd10);
            chk_outputs(tag);
            chk({tag, " stale"}, 40'(stale), 40'(e_stale));
            tick();
            chk({tag, " dv width"}, 40'(data_valid), 40'd0);
        end else begin
            e_err = e_err == 255 ? 255 : e_err + 1;
            tick();
            chk({tag, " crc_err"}, 40'(crc_err), 40'd1);
            chk({tag, " err_cnt"}, 40'(err_cnt), 40'(e_err));
            tick();
            chk({tag, " crc width"}, 40'(crc_err), 40'd0);
            seen = 1'b0;
            repeat (12) begin
                tick();
                seen |= data_valid;
            end
            chk({tag, " no dv"}, 40'(seen), 40'd0);
            chk_outputs({tag, " held"});
        end
    endtask

    task automatic poll_pulse();
        flag_five_sec = 1'b1;
        repeat (2) tick();
        flag_five_sec = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int dv_count;
        logic [39:0] fa;
        logic [39:0] fb;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_outputs("reset");
        chk("reset dv", 40'(data_valid), 40'd0);
        chk("reset crc", 40'(crc_err), 40'd0);
        chk("reset err_cnt", 40'(err_cnt), 40'd0);
        chk("reset stale", 40'(stale), 40'd0);
        chk("reset busy", 40'(busy), 40'd0);

        run_frame(40'h37_00_18_00_4F, "good");
        chk("good hum literal", 40'(hum_bcd), 40'h055);
        chk("good temp literal", 40'(temp_bcd), 40'h024);
        run_frame(40'h80_80_80_01_81, "wrap");
        chk("wrap hum literal", 40'(hum_bcd), 40'h128);
        chk("wrap temp literal", 40'(temp_bcd), 40'h128);
        run_frame(40'h37_00_18_00_50, "bad");
        chk("bad err_cnt literal", 40'(err_cnt), 40'd1);

        for (int i = 0; i < 30; i++) run_frame(make_frame($urandom_range(0, 2) != 0), "rand");
        run_frame({8'd255, 8'd0, 8'd0, 8'd0, 8'd255}, "max");
        run_frame({8'd0, 8'd7, 8'd0, 8'd0, 8'd7}, "zero");

        for (int i = 0; i < 256; i++) run_frame(make_frame(1'b0), "sat");
        chk("sat err_cnt", 40'(err_cnt), 40'd255);

        poll_pulse();
        chk("stale after 1", 40'(stale), 40'd0);
        poll_pulse();
        chk("stale after 2", 40'(stale), 40'd0);
        poll_pulse();
        chk("stale after 3", 40'(stale), 40'd1);
        poll_pulse();
        chk("stale after 4", 40'(stale), 40'd1);
        run_frame(make_frame(1'b1), "unstale");

        fa = make_frame(1'b1);
        fb = {~fa[39:32], ~fa[31:24], fa[23:16], fa[15:8], ~fa[39:32] + ~fa[31:24] + fa[23:16] + fa[15:8]};
        start_frame(fa);
        frame_in = fb;
        repeat (2) tick();
        mstate_in = 3'd2;
        tick();
        mstate_in = 3'd0;
        dv_count = 0;
        repeat (24) begin
            tick();
            if (data_valid) begin
                dv_count++;
                chk("double hum_raw", 40'(hum_raw), 40'(fa[39:32]));
                chk("double hum_bcd", 40'(hum_bcd), 40'(bcd(int'(fa[39:32]))));
            end
        end
        chk("double dv count", 40'(dv_count), 40'd1);
        e_hbcd = bcd(int'(fa[39:32]));
        e_tbcd = bcd(int'(fa[23:16]));
        e_hraw = fa[39:32];
        e_traw = fa[23:16];

        start_frame(make_frame(1'b1));
        repeat (4) tick();
        chk("conv busy", 40'(busy), 40'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_hbcd = '0;
        e_tbcd = '0;
        e_hraw = '0;
        e_traw = '0;
        e_err = 0;
        chk("rst busy", 40'(busy), 40'd0);
        chk_outputs("rst");
        chk("rst err_cnt", 40'(err_cnt), 40'd0);
        chk("rst dv", 40'(data_valid), 40'd0);
        dv_count = 0;
        repeat (12) begin
            tick();
            dv_count += int'(data_valid);
        end
        chk("rst no dv", 40'(dv_count), 40'd0);
        run_frame(make_frame(1'b1), "after rst");
        run_frame(make_frame(1'b0), "after rst bad");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
